// File: rtl/scrypt_pkg.sv
// Shared widths, Integerify word position and ROMix sequencer state encoding.
package scrypt_pkg;

   localparam int unsigned SCRYPT_BLK_W  = 1024;
   localparam int unsigned SCRYPT_WORD_W = 32;

   // Integerify takes word16, the first word of block B[2r-1] for r=1.
   localparam int unsigned INTEGERIFY_HI = 511;
   localparam int unsigned INTEGERIFY_LO = 480;

   typedef enum logic [2:0] {
      StIdle,
      StP1Mix,
      StP1Wait,
      StP2Rd,
      StP2Mix,
      StP2Wait,
      StDone
   } romix_state_t;

endpackage

// File: rtl/romix_scratchpad.sv
// V scratchpad: single-port RAM, synchronous write, registered read, no reset.
module romix_scratchpad
   import scrypt_pkg::*;
#(
   parameter int unsigned Depth = 1024,
   parameter int unsigned AddrW = 10
) (
   input  logic                    clk_i,
   input  logic                    we_i,
   input  logic [AddrW-1:0]        addr_i,
   input  logic [SCRYPT_BLK_W-1:0] wdata_i,
   output logic [SCRYPT_BLK_W-1:0] rdata_o
);

   logic [SCRYPT_BLK_W-1:0] mem_q [Depth];
   logic [SCRYPT_BLK_W-1:0] rdata_q;

   // Write when enabled; read data appears one cycle after the address.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
      rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/romix_ctrl.sv
// ROMix sequencer around one external BlockMix core; owns the V scratchpad.
// Optional feature: define ROMIX_CYCLE_CNT_EN to add the cycle_cnt_o busy-cycle counter.
module romix_ctrl
   import scrypt_pkg::*;
#(
   parameter int unsigned N      = 1024,
   parameter int unsigned ADDR_W = 10
) (
   input  logic                    clk_i,
   input  logic                    reset_ni,
   input  logic                    start_i,
   input  logic [SCRYPT_BLK_W-1:0] in_i,
   output logic [SCRYPT_BLK_W-1:0] out_o,
   output logic                    done_o,
   output logic                    busy_o,
   output logic                    bm_init_o,
   output logic [SCRYPT_BLK_W-1:0] bm_in_o,
   input  logic [SCRYPT_BLK_W-1:0] bm_out_i,
   input  logic                    bm_valid_i
`ifdef ROMIX_CYCLE_CNT_EN
   ,
   output logic [31:0]             cycle_cnt_o
`endif
);

   localparam int unsigned      LastI   = N - 1;
   localparam logic [ADDR_W:0]  LastIdx = LastI[ADDR_W:0];

   romix_state_t            state_q;
   logic [SCRYPT_BLK_W-1:0] x_q;
   logic [SCRYPT_BLK_W-1:0] bm_in_q;
   logic [SCRYPT_BLK_W-1:0] out_q;
   logic [ADDR_W:0]         i_q;
   logic                    bm_init_q;
   logic                    done_q;
   logic                    busy_q;

   logic                    sp_we;
   logic [ADDR_W-1:0]       sp_addr;
   logic [SCRYPT_BLK_W-1:0] sp_rdata;
   logic                    phase2;

   // Scratchpad port: write V[i] in P1_MIX; in phase 2 the address is j = Integerify(X) mod N.
   always_comb begin
      phase2  = (state_q == StP2Rd) || (state_q == StP2Mix) || (state_q == StP2Wait);
      sp_we   = (state_q == StP1Mix);
      sp_addr = phase2 ? x_q[INTEGERIFY_LO +: ADDR_W] : i_q[ADDR_W-1:0];
   end

   romix_scratchpad #(
      .Depth (N),
      .AddrW (ADDR_W)
   ) u_scratchpad (
      .clk_i   (clk_i),
      .we_i    (sp_we),
      .addr_i  (sp_addr),
      .wdata_i (x_q),
      .rdata_o (sp_rdata)
   );

   // ROMix FSM; bm_init/done/busy/out are registered on the transition into their cycle.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q   <= StIdle;
         x_q       <= '0;
         bm_in_q   <= '0;
         out_q     <= '0;
         i_q       <= '0;
         bm_init_q <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         bm_init_q <= 1'b0;
         done_q    <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start_i) begin
                  x_q       <= in_i;
                  bm_in_q   <= in_i;
                  bm_init_q <= 1'b1;
                  i_q       <= '0;
                  busy_q    <= 1'b1;
                  state_q   <= StP1Mix;
               end
            end
            StP1Mix: begin
               state_q <= StP1Wait;
            end
            StP1Wait: begin
               if (bm_valid_i) begin
                  x_q <= bm_out_i;
                  if (i_q == LastIdx) begin
                     i_q     <= '0;
                     state_q <= StP2Rd;
                  end else begin
                     i_q       <= i_q + 1'b1;
                     bm_in_q   <= bm_out_i;
                     bm_init_q <= 1'b1;
                     state_q   <= StP1Mix;
                  end
               end
            end
            StP2Rd: begin
               bm_init_q <= 1'b1;
               state_q   <= StP2Mix;
            end
            StP2Mix: begin
               // Hold the operand for the rest of the BlockMix operation.
               bm_in_q <= x_q ^ sp_rdata;
               state_q <= StP2Wait;
            end
            StP2Wait: begin
               if (bm_valid_i) begin
                  x_q <= bm_out_i;
                  if (i_q == LastIdx) begin
                     out_q   <= bm_out_i;
                     done_q  <= 1'b1;
                     state_q <= StDone;
                  end else begin
                     i_q     <= i_q + 1'b1;
                     state_q <= StP2Rd;
                  end
               end
            end
            StDone: begin
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   // V[j] only arrives in P2_MIX, so the operand is formed combinationally for that one cycle.
   always_comb begin
      bm_in_o = (state_q == StP2Mix) ? (x_q ^ sp_rdata) : bm_in_q;
   end

   assign out_o     = out_q;
   assign done_o    = done_q;
   assign busy_o    = busy_q;
   assign bm_init_o = bm_init_q;

`ifdef ROMIX_CYCLE_CNT_EN
   logic [31:0] cnt_q;

   // Busy-cycle counter; the accepting cycle counts as the first, saturates, freezes after done.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         cnt_q <= '0;
      end else if ((state_q == StIdle) && start_i) begin
         cnt_q <= 32'd1;
      end else if (busy_q && (cnt_q != 32'hFFFF_FFFF)) begin
         cnt_q <= cnt_q + 32'd1;
      end
   end

   assign cycle_cnt_o = cnt_q;
`endif

endmodule
